// File: rtl/fifo_stream_ctrl.sv
// Flow controller for the 16-in / 24-out watermark FIFO: watermark-driven refill,
// fixed-rate pop pacing, occupancy tracking, underrun re-prime and sticky overflow.
module fifo_stream_ctrl #(
  parameter int WRITE_WORD = 16,
  parameter int READ_WORD  = 24,
  parameter int BUF_SIZE   = 512,
  parameter int RATE_DIV   = 1000,
  parameter int SRC_SLACK  = 4,
  parameter int LVL_W      = $clog2(BUF_SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic                  src_req,
  input  logic                  src_valid,
  input  logic [WRITE_WORD-1:0] src_data,
  output logic                  fifo_we,
  output logic [WRITE_WORD-1:0] fifo_din,
  output logic                  fifo_pop,
  input  logic                  fifo_hw,
  input  logic                  fifo_lw,
  output logic                  sample_valid,
  output logic [LVL_W-1:0]      level,
  output logic [15:0]           underrun_cnt,
  output logic                  overflow,
  output logic [1:0]            state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam int DIV_W = $clog2(RATE_DIV);
  localparam int CW    = LVL_W + 2;

  localparam logic [DIV_W-1:0] DIV_RELOAD  = DIV_W'(RATE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
  localparam logic [CW-1:0]    CAP_C       = CW'(BUF_SIZE);
  localparam logic [CW-1:0]    WR_C        = CW'(WRITE_WORD);
  localparam logic [CW-1:0]    RD_C        = CW'(READ_WORD);
  localparam logic [CW-1:0]    REQ_LIMIT_C = CW'(BUF_SIZE - SRC_SLACK * WRITE_WORD);
  localparam logic [LVL_W-1:0] WR_L        = LVL_W'(WRITE_WORD);
  localparam logic [LVL_W-1:0] RD_L        = LVL_W'(READ_WORD);
  localparam logic [LVL_W-1:0] LVL_ZERO    = {LVL_W{1'b0}};

  logic [1:0]            state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  src_req_q, src_req_d;
  logic                  fifo_we_q, fifo_we_d;
  logic [WRITE_WORD-1:0] fifo_din_q, fifo_din_d;
  logic                  fifo_pop_q, fifo_pop_d;
  logic                  sample_valid_q, sample_valid_d;
  logic [15:0]           underrun_cnt_q, underrun_cnt_d;
  logic                  overflow_q, overflow_d;

  logic [CW-1:0] level_ext_s;
  logic          fits_s;
  logic          pop_slot_s;
  logic          can_pop_s;
  logic          do_pop_s;
  logic          underrun_s;

  assign level_ext_s = {2'b00, level_q};
  assign fits_s      = (level_ext_s + WR_C) <= CAP_C;
  // A disable in the same cycle as a due pop suppresses the pop and the underrun check.
  assign pop_slot_s  = (state_q == ST_RUN) && (div_q == {DIV_W{1'b0}}) && enable;
  assign can_pop_s   = level_ext_s >= RD_C;
  assign do_pop_s    = pop_slot_s && can_pop_s;
  assign underrun_s  = pop_slot_s && !can_pop_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_PRIME;
        else        state_d = ST_IDLE;
      end
      ST_PRIME: begin
        if (!enable)     state_d = ST_IDLE;
        else if (fifo_hw) state_d = ST_RUN;
        else             state_d = ST_PRIME;
      end
      ST_RUN: begin
        if (!enable)        state_d = ST_IDLE;
        else if (underrun_s) state_d = ST_PRIME;
        else                state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    div_d = div_q;
    if ((state_q == ST_PRIME) && (state_d == ST_RUN)) begin
      div_d = DIV_RELOAD;
    end else if (state_q == ST_RUN) begin
      if (div_q == {DIV_W{1'b0}}) div_d = DIV_RELOAD;
      else                        div_d = div_q - DIV_ONE;
    end else begin
      div_d = div_q;
    end

    fifo_pop_d     = do_pop_s;
    sample_valid_d = do_pop_s;
    fifo_we_d      = src_valid && fits_s;
    fifo_din_d     = src_data;
    overflow_d     = overflow_q || (src_valid && !fits_s);

    // Writes count when accepted; pops count in the cycle the pulse is on the port.
    level_d = level_q + (fifo_we_d ? WR_L : LVL_ZERO) - (fifo_pop_q ? RD_L : LVL_ZERO);

    if (underrun_s && (underrun_cnt_q != 16'hFFFF)) underrun_cnt_d = underrun_cnt_q + 16'd1;
    else                                            underrun_cnt_d = underrun_cnt_q;

    if ((state_q == ST_IDLE) || fifo_hw || (level_ext_s > REQ_LIMIT_C)) begin
      src_req_d = 1'b0;
    end else if ((state_q == ST_PRIME) || ((state_q == ST_RUN) && fifo_lw)) begin
      src_req_d = 1'b1;
    end else begin
      src_req_d = src_req_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q          <= {DIV_W{1'b0}};
      level_q        <= {LVL_W{1'b0}};
      src_req_q      <= 1'b0;
      fifo_we_q      <= 1'b0;
      fifo_din_q     <= {WRITE_WORD{1'b0}};
      fifo_pop_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      underrun_cnt_q <= 16'd0;
      overflow_q     <= 1'b0;
    end else begin
      div_q          <= div_d;
      level_q        <= level_d;
      src_req_q      <= src_req_d;
      fifo_we_q      <= fifo_we_d;
      fifo_din_q     <= fifo_din_d;
      fifo_pop_q     <= fifo_pop_d;
      sample_valid_q <= sample_valid_d;
      underrun_cnt_q <= underrun_cnt_d;
      overflow_q     <= overflow_d;
    end
  end

  assign state        = state_q;
  assign level        = level_q;
  assign src_req      = src_req_q;
  assign fifo_we      = fifo_we_q;
  assign fifo_din     = fifo_din_q;
  assign fifo_pop     = fifo_pop_q;
  assign sample_valid = sample_valid_q;
  assign underrun_cnt = underrun_cnt_q;
  assign overflow     = overflow_q;

endmodule

// File: doc/fifo_stream_ctrl.md
Name: fifo_stream_ctrl

Overview:
- Flow controller for the 16-bit-in / 24-bit-out watermark FIFO in the streaming output path.
- Refills the FIFO from an upstream word source using the FIFO's high/low watermark flags.
- Paces read-side pops at a fixed sample period.
- Tracks FIFO occupancy, detects underrun and overflow, and re-primes the FIFO after an underrun.

Parameters:
WRITE_WORD, 16, FIFO write word width in bits
READ_WORD, 24, FIFO read word width in bits
BUF_SIZE, 512, FIFO capacity in bits
RATE_DIV, 1000, clock cycles between pops in RUN (minimum 2)
SRC_SLACK, 4, source words that may still arrive after src_req drops
LVL_W, $clog2(BUF_SIZE)+1, width of the occupancy counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  stream enable (level)
src_req  out  1  request words from upstream (level)
src_valid  in  1  src_data valid this cycle
src_data  in  WRITE_WORD  upstream word
fifo_we  out  1  FIFO write enable
fifo_din  out  WRITE_WORD  FIFO write data
fifo_pop  out  1  FIFO pop_front, one-cycle pulse
fifo_hw  in  1  FIFO high-watermark flag
fifo_lw  in  1  FIFO low-watermark flag
sample_valid  out  1  consumer latches FIFO dout this cycle; coincident with fifo_pop
level  out  LVL_W  tracked FIFO occupancy in bits
underrun_cnt  out  16  saturating underrun count
overflow  out  1  sticky; set when a write is dropped
state  out  2  IDLE=0, PRIME=1, RUN=2

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state IDLE, divider 0, level 0. This spec is decided on the basis that the FIFO is flushed by the same system reset; the FIFO flush itself is integration scope.
- Write path, fixed 1-cycle latency: fifo_we <= src_valid && (level + WRITE_WORD <= BUF_SIZE); fifo_din <= src_data.
- src_valid is honoured in every state, including after src_req drops (in-flight words).
- A word failing the capacity check is dropped: fifo_we stays 0 and overflow <= 1 until reset.
- Occupancy accounting:
  - level += WRITE_WORD on each fifo_we cycle.
  - level -= READ_WORD on each fifo_pop cycle.
  - Both in the same cycle: net -8 at defaults.
  - level never wraps: pop is gated below, and writes are gated by the capacity check.
- src_req:
  - Set when state is PRIME, or when state is RUN and fifo_lw=1.
  - Cleared when fifo_hw=1, when level > BUF_SIZE - SRC_SLACK*WRITE_WORD, or when state is IDLE.
  - Otherwise holds its value (hysteresis).
  - The FIFO flags lag writes by about 2 cycles; SRC_SLACK covers this lag.
- State machine:
  - IDLE: src_req=0, no pops. enable=1 -> PRIME.
  - PRIME: src_req=1, no pops. fifo_hw=1 -> RUN with divider loaded to RATE_DIV-1.
  - RUN: divider decrements every cycle. At 0 it reloads to RATE_DIV-1 and:
    - if level >= READ_WORD: fifo_pop=1 and sample_valid=1 for exactly one cycle;
    - else: no pop, underrun_cnt += 1 (saturating at 0xFFFF), next state PRIME.
  - enable=0 in any state -> IDLE the next cycle. A pop due in that same cycle is suppressed. level is retained.
- Pop spacing: pops are at least RATE_DIV >= 2 cycles apart. This satisfies the FIFO's requirement that pop_front return low between pops.
- Simultaneous due-pop and fifo_hw in PRIME: no pop. Transition to RUN; the first pop comes RATE_DIV cycles later.
- The state output encodes the current FSM state.

Test Plan:
- Reset and prime: reset_n low then high, enable=1, source streams every cycle, fifo_hw rises when level > 384 -> state IDLE->PRIME->RUN; src_req drops within 1 cycle of fifo_hw; first fifo_pop exactly RATE_DIV cycles after entering RUN.
- Steady pacing: RATE_DIV=4, source idle after priming with level=400 -> fifo_pop every 4th cycle; level decreases by 24 per pop; src_req reasserts on the cycle after fifo_lw=1.
- Simultaneous write+pop: src_valid in the same cycle a pop fires, level=96 -> level=88 next cycle.
- Underrun: source stalled, level drains to 16 at the pop slot -> no fifo_pop, underrun_cnt 0->1, state PRIME, src_req=1.
- Overflow: level=504, source sends 2 words ignoring src_req -> first word dropped, fifo_we=0, overflow=1 sticky; level stays 504.
- Disable/reset mid-stream: enable=0 in RUN on a due-pop cycle -> no pop, IDLE next cycle, src_req=0, in-flight word still written (level +16); then reset_n=0 asynchronously -> all outputs 0 with no clock edge.
